// File: rtl/freq_dop_mc_pkg.sv
// Shared definitions for the multi-channel square-wave generator.
package freq_dop_mc_pkg;

  // Number of clock edges between an I_load edge and the sampling of
  // I_ch_sel / I_period: two synchroniser flops plus one edge register.
  localparam int LOAD_LAT = 3;

  // Width of the channel-select port. It is never narrower than one bit,
  // so a single-channel build still has a legal port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_dop_ch.sv
// One square-wave channel: half-period counter, active/shadow period,
// pending flag and registered level/edge outputs.
module freq_dop_ch #(
  parameter int CW = 28
) (
  input  logic          I_clk,
  input  logic          I_reset,
  input  logic          I_en,
  input  logic          I_sync,
  input  logic          I_wr,
  input  logic [CW-1:0] I_wr_period,
  output logic          O_spd,
  output logic          O_edge,
  output logic          O_pend
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] p_q, p_d;
  logic [CW-1:0] sh_q, sh_d;
  logic          spd_q, spd_d;
  logic          edge_q, edge_d;
  logic          pend_q, pend_d;
  logic          en_q;
  logic          apply;

  logic [CW-1:0] half;
  logic [CW-1:0] p_next;

  // An odd period truncates: each level lasts P/2 cycles.
  assign half   = {1'b0, p_q[CW-1:1]};
  // Period that a restart would adopt if the shadow were applied now.
  assign p_next = pend_q ? sh_q : p_q;

  // Next-state: disable, restart (sync / first enabled cycle), DC-high, count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d  = cnt_q;
    spd_d  = spd_q;
    edge_d = 1'b0;
    p_d    = p_q;
    apply  = 1'b0;

    if (!I_en) begin
      cnt_d = '0;
      spd_d = 1'b0;
      apply = pend_q;
    end else if (I_sync || !en_q) begin
      // Phase restart: a fresh period always begins with a full high level.
      apply  = pend_q;
      cnt_d  = '0;
      spd_d  = 1'b1;
      edge_d = (p_next >= CW'(2)) || !spd_q;
    end else if (p_q < CW'(2)) begin
      // Degenerate period: output held high, shadow applied immediately.
      apply  = pend_q;
      cnt_d  = '0;
      spd_d  = 1'b1;
      edge_d = !spd_q;
    end else if (cnt_q == half - CW'(1)) begin
      cnt_d = '0;
      spd_d = !spd_q;
      if (!spd_q) begin
        // Low-to-high toggle is the period boundary.
        apply  = pend_q;
        edge_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (apply) p_d = sh_q;

    // A write in the same cycle as an apply keeps the new value pending.
    pend_d = I_wr ? 1'b1 : (apply ? 1'b0 : pend_q);
    sh_d   = I_wr ? I_wr_period : sh_q;
  end

  // Channel state register.
  always_ff @(posedge I_clk or posedge I_reset) begin
    // NOTE: all channel state, including the period registers, is cleared by reset.
    if (I_reset) begin
      cnt_q  <= '0;
      p_q    <= '0;
      sh_q   <= '0;
      spd_q  <= 1'b0;
      edge_q <= 1'b0;
      pend_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      sh_q   <= sh_d;
      spd_q  <= spd_d;
      edge_q <= edge_d;
      pend_q <= pend_d;
      en_q   <= I_en;
    end
  end

  assign O_spd  = spd_q;
  assign O_edge = edge_q;
  assign O_pend = pend_q;

endmodule

// File: rtl/freq_dop_mc.sv
// Multi-channel square-wave generator: load synchroniser, channel decode
// and NCH independent channels.
module freq_dop_mc
  import freq_dop_mc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 28
) (
  input  logic                   I_clk,
  input  logic                   I_reset,
  input  logic [sel_w(NCH)-1:0]  I_ch_sel,
  input  logic [CW-1:0]          I_period,
  input  logic                   I_load,
  input  logic [NCH-1:0]         I_enable,
  input  logic                   I_sync,
  output logic [NCH-1:0]         O_spd,
  output logic [NCH-1:0]         O_edge,
  output logic [NCH-1:0]         O_pend
);

  localparam int SW = sel_w(NCH);

  logic [LOAD_LAT-1:0] sync_q;
  logic                load_rise;
  logic                ld_v_q;
  logic [SW-1:0]       ld_sel_q;
  logic [CW-1:0]       ld_per_q;

  // Rising edge seen between the second synchroniser flop and the edge register.
  assign load_rise = sync_q[LOAD_LAT-2] & ~sync_q[LOAD_LAT-1];

  // I_load synchroniser, edge register and load-sample registers.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      sync_q   <= '0;
      ld_v_q   <= 1'b0;
      ld_sel_q <= '0;
      ld_per_q <= '0;
    end else begin
      sync_q <= {sync_q[LOAD_LAT-2:0], I_load};
      ld_v_q <= load_rise;
      if (load_rise) begin
        ld_sel_q <= I_ch_sel;
        ld_per_q <= I_period;
      end
    end
  end

  // Selects beyond NCH-1 match no channel and are dropped.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    freq_dop_ch #(
      .CW(CW)
    ) u_ch (
      .I_clk       (I_clk),
      .I_reset     (I_reset),
      .I_en        (I_enable[g]),
      .I_sync      (I_sync),
      .I_wr        (ld_v_q && (ld_sel_q == SW'(g))),
      .I_wr_period (ld_per_q),
      .O_spd       (O_spd[g]),
      .O_edge      (O_edge[g]),
      .O_pend      (O_pend[g])
    );
  end

endmodule

// File: tb/tb_freq_dop_mc.sv
// Self-checking bench for freq_dop_mc with a period-position reference model.
module tb_freq_dop_mc;

  localparam int NCH = 4;
  localparam int CW  = 28;
  localparam int SW  = 2;
  localparam int WR_LAT = 4;  // edges from I_load edge to shadow write

  logic           I_clk = 1'b0;
  logic           I_reset = 1'b0;
  logic [SW-1:0]  I_ch_sel = '0;
  logic [CW-1:0]  I_period = '0;
  logic           I_load = 1'b0;
  logic [NCH-1:0] I_enable = '0;
  logic           I_sync = 1'b0;
  logic [NCH-1:0] O_spd, O_edge, O_pend;

  freq_dop_mc #(.NCH(NCH), .CW(CW)) dut (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .I_ch_sel (I_ch_sel),
    .I_period (I_period),
    .I_load   (I_load),
    .I_enable (I_enable),
    .I_sync   (I_sync),
    .O_spd    (O_spd),
    .O_edge   (O_edge),
    .O_pend   (O_pend)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position within the current period (0 .. P-1 rounded
  // down to even), active and shadow periods, pending flag.
  int unsigned m_p[NCH], m_sh[NCH], m_pos[NCH];
  bit          m_pend[NCH], m_spd[NCH], m_edge[NCH], m_enp[NCH];
  logic [NCH-1:0] exp_spd = '0, exp_edge = '0, exp_pend = '0;

  typedef struct { int due; int ch; int unsigned per; } load_t;
  load_t lq[$];
  int cyc = 0;
  int load_age = 0;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_p[c] = 0; m_sh[c] = 0; m_pos[c] = 0;
      m_pend[c] = 0; m_spd[c] = 0; m_edge[c] = 0; m_enp[c] = 0;
    end
    lq.delete();
    exp_spd = '0; exp_edge = '0; exp_pend = '0;
  endtask

  task automatic model_step();
    bit          wr[NCH];
    int unsigned wp[NCH];
    cyc++;
    if (I_reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin wr[c] = 0; wp[c] = 0; end
    while (lq.size() > 0 && lq[0].due == cyc) begin
      if (lq[0].ch < NCH) begin
        wr[lq[0].ch] = 1;
        wp[lq[0].ch] = lq[0].per;
      end
      void'(lq.pop_front());
    end
    for (int c = 0; c < NCH; c++) begin
      int unsigned np;
      bit app;
      app = 0;
      np  = m_pend[c] ? m_sh[c] : m_p[c];
      if (!I_enable[c]) begin
        m_spd[c] = 0; m_edge[c] = 0; m_pos[c] = 0; app = m_pend[c];
      end else if (I_sync || !m_enp[c]) begin
        m_edge[c] = (np >= 2) || !m_spd[c];
        m_spd[c] = 1; m_pos[c] = 0; app = m_pend[c];
      end else if (m_p[c] < 2) begin
        m_edge[c] = !m_spd[c];
        m_spd[c] = 1; m_pos[c] = 0; app = m_pend[c];
      end else begin
        m_pos[c]++;
        m_edge[c] = 0;
        if (m_pos[c] == (m_p[c] / 2) * 2) begin
          m_pos[c] = 0; m_edge[c] = 1; app = m_pend[c];
        end
        m_spd[c] = (m_pos[c] < m_p[c] / 2);
      end
      if (app) begin m_p[c] = m_sh[c]; m_pend[c] = 0; end
      if (wr[c]) begin m_sh[c] = wp[c]; m_pend[c] = 1; end
      m_enp[c] = I_enable[c];
      exp_spd[c] = m_spd[c]; exp_edge[c] = m_edge[c]; exp_pend[c] = m_pend[c];
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge I_clk);
    model_step();
    #1;
    if (load_age > 0) begin
      load_age++;
      if (load_age == 6) I_load = 1'b0;
      if (load_age == 8) load_age = 0;
    end
  endtask

  // Start a load; inputs are held until the next load is started.
  task automatic start_load(input int ch, input int unsigned per);
    I_ch_sel = SW'(ch);
    I_period = CW'(per);
    I_load   = 1'b1;
    lq.push_back('{cyc + WR_LAT, ch, per});
    load_age = 1;
  endtask

  task automatic test_reset();
    #1 I_reset = 1'b1;
    #1;
    n_checks++;
    if ({O_spd, O_edge, O_pend} !== '0)
      $display("FAIL reset_async: spd/edge/pend got %b/%b/%b want 0/0/0", O_spd, O_edge, O_pend);
    else n_pass++;
    model_reset();
    repeat (2) tick();
    n_checks++;
    if ({O_spd, O_edge, O_pend} !== '0)
      $display("FAIL reset_held: spd/edge/pend got %b/%b/%b want 0/0/0", O_spd, O_edge, O_pend);
    else n_pass++;
    I_reset = 1'b0;
  endtask

  task automatic test_basic();
    int n_pend = 0, n_edge = 0, n_high = 0;
    start_load(0, 10);
    repeat (7) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL basic_load cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
      n_pend += int'(O_pend[0]);
    end
    I_enable[0] = 1'b1;
    repeat (40) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL basic_run cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
      n_edge += int'(O_edge[0]);
      n_high += int'(O_spd[0]);
    end
    n_checks++;
    if (n_pend != 1) $display("FAIL basic_pend_len: got %0d cycles want 1", n_pend);
    else n_pass++;
    n_checks++;
    if (n_edge != 4) $display("FAIL basic_edges: got %0d want 4", n_edge);
    else n_pass++;
    n_checks++;
    if (n_high != 20) $display("FAIL basic_duty: got %0d high cycles want 20", n_high);
    else n_pass++;
  endtask

  task automatic test_small_period();
    int n_edge = 0, n_high = 0;
    start_load(1, 1);
    repeat (7) tick();
    I_enable[1] = 1'b1;
    repeat (20) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL small_p1 cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
      n_edge += int'(O_edge[1]);
      n_high += int'(O_spd[1]);
    end
    start_load(1, 0);
    repeat (10) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL small_p0 cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
      n_edge += int'(O_edge[1]);
      n_high += int'(O_spd[1]);
    end
    n_checks++;
    if (n_edge != 1) $display("FAIL small_edges: got %0d want 1", n_edge);
    else n_pass++;
    n_checks++;
    if (n_high != 30) $display("FAIL small_high: got %0d high cycles want 30", n_high);
    else n_pass++;
  endtask

  task automatic test_reload();
    int n_edge = 0, n_fall = 0;
    bit prev_pend;
    for (int i = 0; i < 20 && !exp_edge[0]; i++) tick();
    tick();
    start_load(0, 6);
    prev_pend = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL reload cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
      if (prev_pend && !O_pend[0]) begin
        n_fall++;
        n_checks++;
        if (O_edge[0] !== 1'b1) $display("FAIL reload_pend_boundary: edge got %b want 1", O_edge[0]);
        else n_pass++;
      end
      prev_pend = O_pend[0];
      if (t >= 10) n_edge += int'(O_edge[0]);
    end
    n_checks++;
    if (n_fall != 1) $display("FAIL reload_pend_fall: got %0d want 1", n_fall);
    else n_pass++;
    n_checks++;
    if (n_edge != 3) $display("FAIL reload_edges: got %0d want 3", n_edge);
    else n_pass++;
  endtask

  task automatic test_sync();
    start_load(0, 10);
    repeat (20) tick();
    start_load(2, 14);
    repeat (7) tick();
    I_enable[2] = 1'b1;
    repeat (17) tick();
    I_sync = 1'b1;
    tick();
    I_sync = 1'b0;
    n_checks++;
    if ({O_spd[2], O_spd[0], O_edge[2], O_edge[0]} !== 4'b1111)
      $display("FAIL sync_edge: spd0/spd2/edge0/edge2 got %b/%b/%b/%b want 1/1/1/1",
               O_spd[0], O_spd[2], O_edge[0], O_edge[2]);
    else n_pass++;
    repeat (30) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL sync_run cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
    end
  endtask

  task automatic test_last_wins();
    int n_edge = 0;
    int waited = 0;
    start_load(3, 30);
    repeat (7) tick();
    I_enable[3] = 1'b1;
    repeat (2) tick();
    start_load(3, 8);
    repeat (7) tick();
    start_load(3, 20);
    do begin
      tick();
      waited++;
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL last_wins cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
    end while ((waited < 8 || O_pend[3]) && waited < 40);
    n_checks++;
    if (O_pend[3] !== 1'b0 || O_edge[3] !== 1'b1)
      $display("FAIL last_wins_boundary: pend/edge got %b/%b want 0/1 within 40 cycles",
               O_pend[3], O_edge[3]);
    else n_pass++;
    repeat (39) begin
      tick();
      n_edge += int'(O_edge[3]);
    end
    n_checks++;
    if (n_edge != 1) $display("FAIL last_wins_period: got %0d edges want 1", n_edge);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int k;
      if ($urandom_range(0, 29) == 0) begin
        k = int'($urandom_range(0, NCH - 1));
        I_enable[k] = ~I_enable[k];
      end
      I_sync = ($urandom_range(0, 24) == 0);
      if (load_age == 0 && $urandom_range(0, 3) == 0)
        start_load(int'($urandom_range(0, NCH - 1)), $urandom_range(0, 24));
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL random cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
    end
    I_sync = 1'b0;
    while (load_age != 0) tick();
  endtask

  task automatic test_reset_mid();
    int n_pend = 0;
    I_enable[0] = 1'b1;
    start_load(0, 12);
    repeat (5) tick();
    #2 I_reset = 1'b1;
    #1;
    n_checks++;
    if ({O_spd, O_edge, O_pend} !== '0)
      $display("FAIL reset_mid: spd/edge/pend got %b/%b/%b want 0/0/0", O_spd, O_edge, O_pend);
    else n_pass++;
    I_load = 1'b0;
    load_age = 0;
    model_reset();
    I_enable = '1;
    tick();
    I_reset = 1'b0;
    tick();
    n_checks++;
    if (O_spd !== '1 || O_pend !== '0)
      $display("FAIL reset_release: spd/pend got %b/%b want 1111/0000", O_spd, O_pend);
    else n_pass++;
    repeat (20) begin
      tick();
      n_checks++;
      if ({O_spd, O_edge, O_pend} !== {exp_spd, exp_edge, exp_pend})
        $display("FAIL reset_after cyc %0d: spd/edge/pend got %b/%b/%b want %b/%b/%b",
                 cyc, O_spd, O_edge, O_pend, exp_spd, exp_edge, exp_pend);
      else n_pass++;
      n_pend += int'(|O_pend);
    end
    n_checks++;
    if (n_pend != 0) $display("FAIL reset_discard: pend seen %0d cycles want 0", n_pend);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_period();
    test_reload();
    test_sync();
    test_last_wins();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
